noc_packetizer: RTL and testbench

Clocked network-interface stage that sits directly upstream of a router input port (memory, PE or adder side) and produces the 47-bit NoC packets the router switches consume. It accepts a byte stream with a valid/ready handshake, packs five bytes into the 40-bit data field, prepends the ifm/filt flag, destination and source header, and queues finished packets in a small FIFO drained by a valid/ready output handshake.

---
 rtl/noc_packetizer.sv | 81 ++++++++
 tb/tb_noc_packetizer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// noc_packetizer: packs a byte stream into 47-bit NoC packets {sel, dest, SRC_ADDR, data[39:0]} queued in a FIFO.
// Define NOC_PKT_CNT_EN to add the saturating pkt_cnt output counting popped packets.
module noc_packetizer #(
  parameter logic [2:0] SRC_ADDR = 3'b110,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic [2:0]  in_dest,
  input  logic        in_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [46:0] out_packet,
  output logic        busy
`ifdef NOC_PKT_CNT_EN
  , output logic [15:0] pkt_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [2:0] idx, idx_n, dest_q, dest_n;
  logic sel_q, sel_n, hs, close, pop;
  logic [39:0] acc, data_n;
  logic [5:0] sh;
  logic [46:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count, count_n;
  assign in_ready = ~rst & (count != (AW+1)'(DEPTH));
  assign out_valid = count != '0;
  assign out_packet = out_valid ? mem[rp] : '0;
  assign hs = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign sh = {3'd4 - idx, 3'b000};
  // Byte 0 takes its header straight from the inputs; later bytes reuse the latched header.
  always_comb begin
    dest_n = state == IDLE ? in_dest : dest_q;
    sel_n = state == IDLE ? in_sel : sel_q;
    data_n = (state == IDLE ? 40'd0 : acc) | (40'(in_data) << sh);
    close = hs & (in_last | idx == 3'd4);
    state_n = hs ? (close ? IDLE : FILL) : state;
    idx_n = hs ? (close ? 3'd0 : idx + 3'd1) : idx;
    count_n = count + (AW+1)'(close) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      dest_q <= '0;
      sel_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      count <= count_n;
      busy <= state_n != IDLE || count_n != '0;
      if (hs) begin
        acc <= data_n;
        dest_q <= dest_n;
        sel_q <= sel_n;
      end
      if (close) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (close) mem[wp] <= {sel_n, dest_n, SRC_ADDR, data_n};
`ifdef NOC_PKT_CNT_EN
  always_ff @(posedge clk)
    if (rst) pkt_cnt <= '0;
    else if (pop && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: table vectors, hand sequences and randomized traffic against a queue-based packet model.
module tb_noc_packetizer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, in_sel = 0, ord = 0, rnd_on = 0, rnd_r = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_dest = 0;
  logic in_ready, out_valid, out_ready, busy;
  logic [46:0] out_packet;
  int checks = 0, failures = 0;
`ifdef NOC_PKT_CNT_EN
  logic [15:0] pkt_cnt;
  int mcnt = 0;
`endif
  assign out_ready = rnd_on ? rnd_r : ord;
  noc_packetizer #(.SRC_ADDR(3'b110), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_dest(in_dest), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_packet(out_packet), .busy(busy)
`ifdef NOC_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rnd_on) #1 rnd_r = 1'($urandom_range(0, 1));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  // Reference model: bytes accepted so far for the open packet and packets awaiting pop.
  logic [7:0] cur[$];
  logic [46:0] exp_q[$];
  logic [2:0] h_dest;
  logic h_sel, hold = 0;
  logic [46:0] held;
  function automatic logic [46:0] build(input logic s, input logic [2:0] d, input logic [7:0] b[$]);
    logic [39:0] data = 0;
    for (int i = 0; i < b.size(); i++) data = data | (40'(b[i]) << (8 * (4 - i)));
    return {s, d, 3'b110, data};
  endfunction
  always @(negedge clk) begin
    chk("busy", busy, cur.size() > 0 || exp_q.size() > 0);
    chk("in_ready", in_ready, !rst && exp_q.size() < DEPTH);
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("head", out_packet, exp_q[0]);
    if (hold) chk("stable", out_packet, held);
`ifdef NOC_PKT_CNT_EN
    chk("pkt_cnt", pkt_cnt, 16'(mcnt));
`endif
    hold = out_valid && !out_ready && !rst;
    held = out_packet;
    if (rst) begin
      cur.delete();
      exp_q.delete();
`ifdef NOC_PKT_CNT_EN
      mcnt = 0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
`ifdef NOC_PKT_CNT_EN
        if (mcnt < 65535) mcnt++;
`endif
      end
      if (in_valid && in_ready) begin
        if (cur.size() == 0) begin
          h_dest = in_dest;
          h_sel = in_sel;
        end
        cur.push_back(in_data);
        if (in_last || cur.size() == 5) begin
          exp_q.push_back(build(h_sel, h_dest, cur));
          cur.delete();
        end
      end
    end
  end

  task automatic wait_accept();
    logic ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic send_byte(input logic [7:0] d, input logic l, input logic [2:0] ds, input logic s);
    in_valid = 1;
    in_data = d;
    in_last = l;
    in_dest = ds;
    in_sel = s;
    wait_accept();
  endtask

  typedef struct {
    logic [7:0] b[5];
    int n;
    logic [2:0] dest;
    logic sel;
    logic [46:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{'{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 5, 3'b011, 1'b0, {1'b0, 3'b011, 3'b110, 40'h1122334455}};
    tbl[1] = '{'{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00}, 2, 3'b100, 1'b1, {1'b1, 3'b100, 3'b110, 40'hAABB000000}};
    tbl[2] = '{'{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 5, 3'b001, 1'b0, {1'b0, 3'b001, 3'b110, 40'h0102030405}};
    tbl[3] = '{'{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 3'b111, 1'b1, {1'b1, 3'b111, 3'b110, 40'h7F00000000}};
    tbl[4] = '{'{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 4, 3'b010, 1'b0, {1'b0, 3'b010, 3'b110, 40'hDEADBEEF00}};
    tbl[5] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5, 3'b000, 1'b1, {1'b1, 3'b000, 3'b110, 40'hFFFFFFFFFF}};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_packet", out_packet, 0);
    @(posedge clk);
    #1 rst = 0;
    ord = 1;
    // Header inputs are inverted after byte 0 so any late resampling shows up.
    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].n; i++)
        send_byte(tbl[v].b[i], i == tbl[v].n - 1 && tbl[v].n < 5,
                  i == 0 ? tbl[v].dest : ~tbl[v].dest, i == 0 ? tbl[v].sel : ~tbl[v].sel);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), out_valid, 1);
      chk($sformatf("vec%0d_packet", v), out_packet, tbl[v].exp);
      @(posedge clk);
      #1;
    end
    // Backpressure: fill the FIFO, stall the 21st byte, then release.
    ord = 0;
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b0, 3'(i / 5), 1'b0);
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1;
    in_data = 8'hC5;
    in_dest = 3'b101;
    in_sel = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 ord = 1;
    wait_accept();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC6 + i), 1'b0, 3'b000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    // Reset with a queued packet and a partial one held.
    ord = 0;
    for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i), 1'b0, 3'b010, 1'b1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 ord = 1;
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0, 3'b011, 1'b0);
    @(negedge clk);
    chk("post_rst_packet", out_packet, {1'b0, 3'b011, 3'b110, 40'h0102030405});
    @(posedge clk);
    #1;
    // Randomized traffic with random output backpressure.
    rnd_on = 1;
    for (int p = 0; p < 60; p++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        send_byte(8'($urandom), i == n - 1 && (n < 5 || $urandom_range(0, 1) == 1),
                  3'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 0;
    ord = 1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
